// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state, mode encodings and rest-code helper for the LED note scope
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_HOLD   = 2'd1;
  localparam logic [1:0] MODE_BAR    = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // The rest code sits just past the last playable note.
  function automatic int unsigned rest_code(input int unsigned num_leds);
    return num_leds;
  endfunction

endpackage

// File: rtl/led_down_counter.sv
// rtl/led_down_counter.sv - loadable down counter with zero flag, stops at zero
module led_down_counter #(
  parameter int          W    = 4,
  parameter int unsigned FULL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= W'(FULL);
    else if (en && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/led_note_scope.sv
// rtl/led_note_scope.sv - note-to-LED display FSM with direct, hold, bar and error-blink modes
module led_note_scope
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned NOTE_W    = 4,
  parameter int unsigned HOLD_CYC  = 12_500_000,
  parameter int unsigned BLINK_CYC = 6_250_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NOTE_W-1:0]   note,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] Led,
  output logic                err
);

  localparam int HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(rest_code(NUM_LEDS));

  state_t                state, state_d;
  logic [NOTE_W-1:0]     last_note, last_d;
  logic                  phase, phase_d;
  logic                  hold_load, hold_en, hold_zero;
  logic                  blink_load, blink_en, blink_zero;
  logic [NUM_LEDS-1:0]   oh_note, oh_last, bar, led_d;
  logic                  err_d;
  logic                  is_rest, is_note, is_bad;

  assign is_rest = (note == REST);
  assign is_note = (note < REST);
  assign is_bad  = (note > REST);

  always_comb begin
    oh_note = '0;
    oh_last = '0;
    bar     = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      oh_note[i] = (note == NOTE_W'(NUM_LEDS - 1 - i));
      oh_last[i] = (last_note == NOTE_W'(NUM_LEDS - 1 - i));
      bar[i]     = (note <= NOTE_W'(NUM_LEDS - 1 - i));
    end
  end

  // Both counters are loaded with full-1 so the zero flag lands on the last lit cycle.
  led_down_counter #(.W(HOLD_W), .FULL(HOLD_CYC - 1)) u_hold_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .en   (hold_en),
    .zero (hold_zero)
  );

  led_down_counter #(.W(BLINK_W), .FULL(BLINK_CYC - 1)) u_blink_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (blink_load),
    .en   (blink_en),
    .zero (blink_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_note <= '0;
      phase     <= 1'b0;
      Led       <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      last_note <= last_d;
      phase     <= phase_d;
      Led       <= led_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    last_d     = last_note;
    phase_d    = phase;
    hold_load  = 1'b0;
    hold_en    = 1'b0;
    blink_load = 1'b0;
    blink_en   = 1'b0;
    if (is_bad) begin
      state_d = ST_ERROR;
      if (state != ST_ERROR) begin
        blink_load = 1'b1;
        phase_d    = 1'b1;
      end else if (blink_zero) begin
        blink_load = 1'b1;
        phase_d    = ~phase;
      end else begin
        blink_en = 1'b1;
      end
    end else if (is_note) begin
      state_d = ST_PLAY;
      last_d  = note;
    end else if (is_rest) begin
      case (state)
        ST_PLAY: begin
          if (mode == MODE_HOLD) begin
            state_d   = ST_HOLD;
            hold_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if ((mode != MODE_HOLD) || hold_zero)
            state_d = ST_IDLE;
          else
            hold_en = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    err_d = (state_d == ST_ERROR);
    case (state_d)
      ST_PLAY:  led_d = (mode == MODE_BAR) ? bar : oh_note;
      ST_HOLD:  led_d = oh_last;
      ST_ERROR: led_d = {NUM_LEDS{phase_d}};
      default:  led_d = '0;
    endcase
  end

endmodule

// File: doc/led_note_scope.md
LED_NOTE_SCOPE -- requirements
Module: led_note_scope

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of LEDs and number of playable notes, range 2..16.
REQ-002 Parameter NOTE_W, default 4: note code width; must satisfy 2^NOTE_W > NUM_LEDS.
REQ-003 Parameter HOLD_CYC, default 12_500_000: cycles an LED stays lit after its note is released in hold mode, at least 1.
REQ-004 Parameter BLINK_CYC, default 6_250_000: half-period of the error blink, in cycles, at least 1.
REQ-005 clk  in  1  system clock; one clock domain; all logic is rising-edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 note  in  NOTE_W  note code: 0..NUM_LEDS-1 are notes (0 is the highest pitch), NUM_LEDS is rest, anything above NUM_LEDS is invalid.
REQ-008 mode  in  2  display mode: 0 DIRECT, 1 HOLD, 2 BAR, 3 reserved (behaves as DIRECT).
REQ-009 Led  out  NUM_LEDS  registered LED drive, 1 = lit.
REQ-010 err  out  1  registered flag, high while state is ERROR.

Function
REQ-011 Note k maps to Led bit (NUM_LEDS-1-k); call this one-hot vector onehot(k).
REQ-012 The block is a state machine with states IDLE, PLAY, HOLD and ERROR.
REQ-013 Transitions on an invalid code: any state goes to ERROR.
REQ-014 Transitions on a valid note: any state goes to PLAY and latches the note into last_note.
REQ-015 Transitions on rest from PLAY: go to HOLD and load the hold counter when mode=1; otherwise go to IDLE.
REQ-016 Transitions in HOLD: decrement the counter each rest cycle; go to IDLE on the cycle the counter reaches 0 (Led is lit for exactly HOLD_CYC cycles after the first rest cycle).
REQ-017 Transitions from ERROR: a rest code goes to IDLE.
REQ-018 Led in IDLE is all zeros.
REQ-019 Led in PLAY with mode 0 or 3 is onehot(note).
REQ-020 Led in PLAY with mode 2 is the bar: every bit from bit 0 up to and including onehot's bit is lit; the bar for note NUM_LEDS-1 is 1 LED, the bar for note 0 is all LEDs.
REQ-021 Led in HOLD is onehot(last_note).
REQ-022 Led in ERROR alternates all-ones and all-zeros every BLINK_CYC cycles, starting all-ones on the first ERROR cycle.
REQ-023 Latency: Led and err reflect the note and mode sampled at edge N after edge N+1, i.e. one registered stage; no combinational path from inputs to outputs.
REQ-024 A new valid note during HOLD restarts PLAY immediately and discards the remaining hold time.
REQ-025 A mode change takes effect at the next edge; leaving mode 1 while in HOLD goes to IDLE.
REQ-026 The hold counter and blink counter saturate or wrap only inside their own state and restart from full on every entry.

Reset
REQ-027 While rst is high at an edge: state=IDLE, Led=0, err=0, last_note=0, all counters=0.
REQ-028 Reset overrides every other input in the same cycle, including mid-HOLD and mid-ERROR; there is no reset to a lit state.

Structure
REQ-029 A shared package led_pkg holds the state enumeration, the mode encodings and a function giving the rest code (NUM_LEDS).
REQ-030 The cycle counter used for both hold and blink is one sub-module, led_down_counter (load, enable, zero flag), instantiated twice.
REQ-031 Target size is 120-400 lines of RTL; no memories and no inferred latches.

Verification (test parameters: NUM_LEDS=8, HOLD_CYC=4, BLINK_CYC=3)
REQ-032 Reset released, note=8 -> Led=00000000 and err=0 on every cycle.
REQ-033 Mode 0, note=0 then note=7 -> Led=10000000 one cycle after the first input, then 00000001 one cycle after the second.
REQ-034 Mode 1, note=3 for 2 cycles, then rest -> Led=00010000 for exactly 4 cycles after the first rest, then 00000000; a new note=5 arriving on the second hold cycle -> Led=00000100 on the next cycle.
REQ-035 Mode 2, note=5 -> Led=00000111; note=0 -> Led=11111111.
REQ-036 Note=12 -> err=1 and Led goes 11111111 for 3 cycles, then 00000000 for 3 cycles, repeating; rest -> IDLE, err=0.
REQ-037 rst asserted mid-HOLD and mid-ERROR -> Led=0 and err=0 on the next cycle; the counters are reloaded from full on the next entry.
